// File: rtl/grass_round_ctrl.sv
// Round scheduler for the Grasshopper block datapath: accepts a block, iterates it
// through the external round logic ROUNDS times, returns it. Optional: GRASS_ROUND_CTRL_DEC_EN.
module grass_round_ctrl #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned ROUNDS  = 10,
  parameter int unsigned RND_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef GRASS_ROUND_CTRL_DEC_EN
  input  logic              dec_i,
  output logic              rnd_inv_o,
`endif
  output logic              rnd_valid_o,
  output logic [3:0]        rnd_stage_o,
  output logic              rnd_last_o,
  output logic [DATA_W-1:0] rnd_data_o,
  input  logic [DATA_W-1:0] rnd_data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned          LAT_W     = $clog2(RND_LAT + 1);
  localparam logic [LAT_W-1:0]     LAT_MAX   = LAT_W'(RND_LAT);
  localparam logic [3:0]           STAGE_MAX = 4'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        stage_q, stage_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              dec_q, dec_d;
  logic              dec_in;
  logic              final_round;

`ifdef GRASS_ROUND_CTRL_DEC_EN
  assign dec_in    = dec_i;
  assign rnd_inv_o = (fsm_q == RUN) & dec_q;
`else
  assign dec_in    = 1'b0;
`endif

  // Decrypt walks the key schedule backwards, so its final round is stage 0.
  assign final_round = dec_q ? (stage_q == 4'd0) : (stage_q == STAGE_MAX);

  assign rnd_data_o = data_q;
  assign out_data   = data_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    fsm_d       = fsm_q;
    data_d      = data_q;
    stage_d     = stage_q;
    lat_d       = lat_q;
    dec_d       = dec_q;
    in_ready    = 1'b0;
    busy        = (fsm_q != IDLE);
    rnd_valid_o = 1'b0;
    rnd_stage_o = 4'd0;
    rnd_last_o  = 1'b0;
    out_valid   = 1'b0;

    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          dec_d   = dec_in;
          stage_d = dec_in ? STAGE_MAX : 4'd0;
          lat_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        rnd_valid_o = (lat_q == '0);
        rnd_stage_o = stage_q;
        rnd_last_o  = final_round;
        lat_d       = lat_q + LAT_W'(1);
        if (lat_q == LAT_MAX) begin
          data_d = rnd_data_i;
          lat_d  = '0;
          if (final_round) begin
            fsm_d = DONE;
          end else begin
            stage_d = dec_q ? (stage_q - 4'd1) : (stage_q + 4'd1);
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the data register is cleared on reset
  // too so rnd_data_o/out_data never expose a stale block after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      data_q  <= '0;
      stage_q <= 4'd0;
      lat_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      stage_q <= stage_d;
      lat_q   <= lat_d;
      dec_q   <= dec_d;
    end
  end

endmodule

// File: doc/grass_round_ctrl.md
Name: grass_round_ctrl

Overview:
- Round scheduler for the Grasshopper (Kuznyechik) block datapath.
- Accepts one 128-bit block over a valid/ready handshake and owns the round counter (stage_num) that selects the round key in key_xor.
- Feeds the current state into the external round datapath, waits its fixed latency and captures the result, for ROUNDS rounds.
- Returns the finished block over a second valid/ready handshake. Sits between the input block interface and the key_xor/S/L round logic.

Parameters:
- DATA_W, 128, block/state width.
- ROUNDS, 10, round iterations per block; legal range 1..16 (stage is 4 bits).
- RND_LAT, 1, cycles from rnd_valid_o to valid rnd_data_i; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  DATA_W  plaintext block.
- rnd_valid_o  out  1  one-cycle pulse: round issue.
- rnd_stage_o  out  4  round/key index to key_xor stage_num.
- rnd_last_o  out  1  current round is final; datapath applies key XOR only.
- rnd_data_o  out  DATA_W  state fed to the datapath.
- rnd_data_i  in  DATA_W  datapath result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  result block.
- busy  out  1  block in flight (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values (any cycle, including mid-block):
  - State returns to IDLE; any in-flight block is dropped with no output.
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, rnd_valid_o=0, rnd_stage_o=0, rnd_last_o=0, busy=0.
  - Data registers = 0, so rnd_data_o=0 and out_data=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_reg<=in_data, stage<=0, lat_cnt<=0, go to RUN.
  - in_ready is combinational from the FSM state (IDLE only).
- RUN:
  - in_ready=0; in_valid ignored.
  - rnd_data_o=state_reg and rnd_stage_o=stage, both held stable for the whole round.
  - rnd_valid_o=1 only when lat_cnt==0.
  - rnd_last_o=1 for the whole round when stage==ROUNDS-1.
  - lat_cnt increments each cycle. When lat_cnt==RND_LAT: state_reg<=rnd_data_i and lat_cnt<=0.
    - If the round was final, go to DONE.
    - Otherwise stage<=stage+1, stay in RUN.
  - Each round takes exactly RND_LAT+1 cycles; the block takes ROUNDS*(RND_LAT+1) RUN cycles.
- DONE:
  - out_valid=1, out_data=state_reg, held stable while out_ready=0 (no limit on backpressure).
  - On out_ready: go to IDLE. in_ready rises the next cycle; no same-cycle accept/emit bypass.
- Latency: out_valid first high ROUNDS*(RND_LAT+1)+1 cycles after the accepting cycle. For defaults: 21.
- Throughput: one block per ROUNDS*(RND_LAT+1)+2 cycles with no backpressure.
- Stage counter: never wraps; max value ROUNDS-1. lat_cnt width = clog2(RND_LAT+1).
- rnd_data_i is sampled only in the capture cycle; its value in all other cycles is don't-care.

Optional Feature:
- Macro: GRASS_ROUND_CTRL_DEC_EN.
- Defined:
  - Adds input dec_i (1 bit), sampled only on input accept and stored in a dec flag.
  - Adds output rnd_inv_o = stored dec flag during RUN, 0 otherwise.
  - When dec: stage starts at ROUNDS-1 and decrements to 0; rnd_last_o is high when stage==0.
  - All timing is identical to encrypt.
- Undefined: encrypt only; dec_i and rnd_inv_o absent; stage always counts up.

Test Plan:
- Bench model datapath for all cases: rnd_data_i = register(rnd_data_o ^ stage), latency RND_LAT.
- Reset, then idle 5 cycles -> in_ready=1, busy=0, out_valid=0, rnd_valid_o=0, rnd_stage_o=0.
- Encrypt, defaults, in_data=0, out_ready=1:
  - rnd_stage_o sequence 0..9, each held 2 cycles.
  - rnd_valid_o pulses 10 times; rnd_last_o high only at stage 9.
  - out_valid exactly 21 cycles after accept; out_data=128'h1.
- Backpressure: out_ready=0 for 8 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 the next cycle.
- RND_LAT=3, in_data=128'hFF -> each stage held 4 cycles; out_valid 41 cycles after accept; out_data=128'hFE.
- rst asserted during stage 4 -> next cycle: IDLE, busy=0, rnd_stage_o=0, out_valid=0. A new block accepted afterwards completes normally with the correct result.
- GRASS_ROUND_CTRL_DEC_EN, dec_i=1, in_data=0:
  - stage sequence 9..0; rnd_last_o only at stage 0; rnd_inv_o=1 throughout RUN.
  - out_data=128'h1.
